// File: rtl/spio_hss_rx_merge.sv
// Purpose : merges 8 multiplexer RX packet channels into one stream, round-robin.
// Latency : 1 cycle from input acceptance to OUT_VLD_OUT into an empty buffer.
// Backpressure: 2-entry buffer; IN_RDY_OUT depends only on registered occupancy.
//
// Ports:
//   CLK_IN, RESET_IN          clock, synchronous active-high reset
//   IN_DATA_IN/VLD_IN/RDY_OUT 8 packet channels (channel i at [i*PKT_BITS +: PKT_BITS])
//   OUT_DATA/CH/VLD_OUT       merged packet, its source channel, valid
//   OUT_RDY_IN                downstream ready
//   PKT_COUNT_OUT             output transfer counter, COUNT_CLEAR_IN zeroes it
//
// Packet width normally comes from the multiplexer common header; a 72-bit
// default applies when it has not already been defined.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module spio_hss_rx_merge #(
    parameter int PKT_COUNT_BITS = 32
) (
    input  logic                        CLK_IN,
    input  logic                        RESET_IN,
    input  logic [8*`PKT_BITS-1:0]      IN_DATA_IN,
    input  logic [7:0]                  IN_VLD_IN,
    output logic [7:0]                  IN_RDY_OUT,
    output logic [`PKT_BITS-1:0]        OUT_DATA_OUT,
    output logic [2:0]                  OUT_CH_OUT,
    output logic                        OUT_VLD_OUT,
    input  logic                        OUT_RDY_IN,
    output logic [PKT_COUNT_BITS-1:0]   PKT_COUNT_OUT,
    input  logic                        COUNT_CLEAR_IN
);

    localparam int PB = `PKT_BITS;

    typedef struct packed {
        logic [PB-1:0] dat;
        logic [2:0]    ch;
    } entry_t;

    entry_t                    head_q, head_d;
    entry_t                    tail_q, tail_d;
    logic [1:0]                occ_q, occ_d;
    logic [2:0]                ptr_q, ptr_d;
    logic [PKT_COUNT_BITS-1:0] cnt_q, cnt_d;

    logic       found;
    logic [2:0] grant_idx;
    logic [2:0] idx;
    logic       space;
    logic       in_xfer;
    logic       out_xfer;
    entry_t     in_entry;

    // Round-robin search starting just after the last granted channel; the
    // eighth step wraps back to the pointer itself so it is checked last.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr_q;
        idx       = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && IN_VLD_IN[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Space is a function of registered occupancy only, so downstream ready
    // never reaches IN_RDY_OUT; a full buffer refuses even while popping.
    assign space      = (occ_q != 2'd2);
    assign in_xfer    = found & space & ~RESET_IN;
    assign IN_RDY_OUT = in_xfer ? (8'b1 << grant_idx) : 8'b0;
    assign out_xfer   = OUT_VLD_OUT & OUT_RDY_IN;
    assign in_entry   = '{dat: IN_DATA_IN[grant_idx*PB +: PB], ch: grant_idx};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        ptr_d  = ptr_q;
        case ({in_xfer, out_xfer})
            2'b10: begin
                if (occ_q == 2'd0) head_d = in_entry;
                else               tail_d = in_entry;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            // Push and pop together only happen at occupancy 1: the new
            // packet replaces the departing head directly.
            2'b11:   head_d = in_entry;
            default: ;
        endcase
        if (in_xfer) ptr_d = grant_idx;
        if (COUNT_CLEAR_IN) cnt_d = '0;
        else                cnt_d = cnt_q + PKT_COUNT_BITS'(out_xfer);
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            ptr_q  <= 3'd7;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign OUT_VLD_OUT   = (occ_q != 2'd0);
    assign OUT_DATA_OUT  = head_q.dat;
    assign OUT_CH_OUT    = head_q.ch;
    assign PKT_COUNT_OUT = cnt_q;

endmodule

// File: doc/spio_hss_rx_merge.md
SPIO_HSS_RX_MERGE -- requirements
Module: spio_hss_rx_merge

Interface
REQ-001 Parameter PKT_COUNT_BITS, default 32, width of the merged-packet counter.
REQ-002 Packet width SHALL be `PKT_BITS from spio_hss_multiplexer_common.h; 8 input channels, fixed.
REQ-003 CLK_IN  input  1  sole clock; all state changes on rising edge.
REQ-004 RESET_IN  input  1  synchronous, active-high reset.
REQ-005 IN_DATA_IN  input  8*`PKT_BITS  channel i packet at bits [i*`PKT_BITS +: `PKT_BITS]; fed by multiplexer RX_PKTi_DATA_OUT.
REQ-006 IN_VLD_IN  input  8  bit i = channel i packet valid.
REQ-007 IN_RDY_OUT  output  8  bit i = channel i packet accepted this cycle if valid.
REQ-008 OUT_DATA_OUT  output  `PKT_BITS  merged packet.
REQ-009 OUT_CH_OUT  output  3  source channel of OUT_DATA_OUT.
REQ-010 OUT_VLD_OUT  output  1  merged packet valid.
REQ-011 OUT_RDY_IN  input  1  downstream ready.
REQ-012 PKT_COUNT_OUT  output  PKT_COUNT_BITS  count of packets transferred on output.
REQ-013 COUNT_CLEAR_IN  input  1  zero PKT_COUNT_OUT.

Function
REQ-014 Transfer on any port SHALL occur iff VLD and RDY are both high at a rising edge; sources hold VLD/data until transfer.
REQ-015 Block SHALL hold a 2-entry FIFO of {data, channel}; OUT_VLD_OUT = occupancy != 0; OUT_DATA_OUT/OUT_CH_OUT = head entry, driven from registers.
REQ-016 space = (occupancy < 2), from registered state only; no combinational path from OUT_RDY_IN to IN_RDY_OUT.
REQ-017 Occupancy update: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither; full (2) never pushes even if popping that cycle.
REQ-018 Arbiter: round-robin pointer P (3 bits); grant = first i with IN_VLD_IN[i] searching P+1, P+2, ... mod 8 (wraps 7->0); grant is zero or one-hot.
REQ-019 IN_RDY_OUT[i] = grant[i] & space; at most one bit high per cycle; all zero when no channel valid or not space.
REQ-020 P SHALL update to the granted channel only on an actual input transfer; otherwise unchanged.
REQ-021 Latency: packet accepted at edge N into empty FIFO appears with OUT_VLD_OUT=1 after edge N (cycle N+1); FIFO order preserved.
REQ-022 Throughput: with OUT_RDY_IN held 1 and any channel valid, one packet/cycle sustained (occupancy steady at 1).
REQ-023 Counter SHALL increment by 1 on each output transfer, wrapping 2^PKT_COUNT_BITS-1 -> 0.
REQ-024 COUNT_CLEAR_IN=1 SHALL set counter to 0 next edge; takes priority over a simultaneous increment (result 0).
REQ-025 Input data SHALL be captured unmodified; no packet duplication or loss except on reset.

Reset
REQ-026 While RESET_IN=1 at an edge: occupancy 0, P=7, counter 0; after that edge OUT_VLD_OUT=0, PKT_COUNT_OUT=0, IN_RDY_OUT=0 while RESET_IN high.
REQ-027 OUT_DATA_OUT/OUT_CH_OUT after reset: 0.
REQ-028 Reset mid-operation SHALL discard buffered packets; no transfers complete at an edge where RESET_IN=1.
REQ-029 First grant after reset with all channels valid SHALL be channel 0.

Verification
REQ-030 All 8 valid continuously, OUT_RDY_IN=1 -> output channels 0,1,...,7,0,1 one per cycle; PKT_COUNT_OUT=16 after 16 outputs.
REQ-031 Only channels 2 and 5 valid, P=7 -> grants 2,5,2,5; channel 5 pre-valid alone after grant 5 -> grant 5 again.
REQ-032 OUT_RDY_IN=0, channel 3 valid with data A,B,C -> A,B accepted, IN_RDY_OUT=0 afterwards; raise OUT_RDY_IN -> A then B output, C accepted only after occupancy <2.
REQ-033 PKT_COUNT_BITS=4, 17 outputs -> count wraps to 1; COUNT_CLEAR_IN coincident with output -> count 0.
REQ-034 RESET_IN pulse with 2 buffered packets -> OUT_VLD_OUT=0 next cycle, count 0, subsequent all-valid grant starts at channel 0.
REQ-035 Random VLD/RDY stimulus, 10k cycles -> scoreboard per channel: no loss, no duplication, per-channel order preserved, OUT_CH_OUT correct.
